// File: rtl/ps_eop_inserter.sv
`default_nettype none
// ============================================================================
// Module   : ps_eop_inserter
// Purpose  : Cuts an unframed word stream into packets by flagging every
//            N-th accepted word as end-of-packet, where N = max(i_len, 1).
//            i_len is sampled only on the first word of each packet. The
//            output is registered through a 2-entry skid buffer, so i_rdy
//            is a flop with no combinational path from o_rdy.
// Ports    : clk    - single clock, rising edge
//            reset  - synchronous active-high reset
//            i_len  - packet length in words (0 behaves as 1)
//            i_dat  - input data word
//            i_val  - input valid
//            i_rdy  - input ready (transfer on i_val & i_rdy)
//            o_dat  - output data word
//            o_val  - output valid
//            o_eop  - last word of packet, qualified by o_val
//            o_rdy  - downstream ready (transfer on o_val & o_rdy)
// Revision : 1.0 - initial release
// ============================================================================
module ps_eop_inserter #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic [WIDTH-1:0]     i_dat,
    input  logic                 i_val,
    output logic                 i_rdy,
    output logic [WIDTH-1:0]     o_dat,
    output logic                 o_val,
    output logic                 o_eop,
    input  logic                 o_rdy
);

    localparam logic [LEN_WIDTH-1:0] C_ONE = LEN_WIDTH'(1);

    // Packet framing state
    logic [LEN_WIDTH-1:0] r_cnt_q, w_cnt_d;
    logic [LEN_WIDTH-1:0] r_len_q, w_len_d;

    // Output register and skid register, each holding {dat, eop}
    logic                 r_out_val_q,  w_out_val_d;
    logic [WIDTH-1:0]     r_out_dat_q,  w_out_dat_d;
    logic                 r_out_eop_q,  w_out_eop_d;
    logic                 r_skid_val_q, w_skid_val_d;
    logic [WIDTH-1:0]     r_skid_dat_q, w_skid_dat_d;
    logic                 r_skid_eop_q, w_skid_eop_d;
    logic                 r_rdy_q,      w_rdy_d;

    logic                 w_acc;
    logic                 w_out_free;
    logic                 w_eop;
    logic [LEN_WIDTH-1:0] w_len_eff;
    logic [LEN_WIDTH-1:0] w_len_cur;

    always_comb begin
        w_acc      = i_val & r_rdy_q;
        w_len_eff  = (i_len == '0) ? C_ONE : i_len;
        // The live i_len only matters on the first word; afterwards the
        // latched length governs so mid-packet changes are ignored.
        w_len_cur  = (r_cnt_q == '0) ? w_len_eff : r_len_q;
        w_eop      = (r_cnt_q == (w_len_cur - C_ONE));

        w_cnt_d    = r_cnt_q;
        w_len_d    = r_len_q;
        if (w_acc) begin
            if (r_cnt_q == '0) begin
                w_len_d = w_len_eff;
            end
            w_cnt_d = w_eop ? '0 : (r_cnt_q + C_ONE);
        end
    end

    always_comb begin
        w_out_free   = ~r_out_val_q | o_rdy;

        w_out_val_d  = r_out_val_q;
        w_out_dat_d  = r_out_dat_q;
        w_out_eop_d  = r_out_eop_q;
        w_skid_val_d = r_skid_val_q;
        w_skid_dat_d = r_skid_dat_q;
        w_skid_eop_d = r_skid_eop_q;

        if (r_skid_val_q) begin
            // i_rdy is low whenever the skid is occupied, so no input can
            // arrive here; the skid word moves forward first, keeping order.
            if (w_out_free) begin
                w_out_val_d  = 1'b1;
                w_out_dat_d  = r_skid_dat_q;
                w_out_eop_d  = r_skid_eop_q;
                w_skid_val_d = 1'b0;
            end
        end else if (w_acc) begin
            if (w_out_free) begin
                w_out_val_d = 1'b1;
                w_out_dat_d = i_dat;
                w_out_eop_d = w_eop;
            end else begin
                w_skid_val_d = 1'b1;
                w_skid_dat_d = i_dat;
                w_skid_eop_d = w_eop;
            end
        end else if (o_rdy) begin
            w_out_val_d = 1'b0;
        end

        // Ready follows the next skid occupancy, so it drops in the same
        // edge that fills the skid and no third word is ever accepted.
        w_rdy_d = ~w_skid_val_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q      <= '0;
            r_len_q      <= C_ONE;
            r_out_val_q  <= 1'b0;
            r_out_eop_q  <= 1'b0;
            r_skid_val_q <= 1'b0;
            r_skid_eop_q <= 1'b0;
            r_rdy_q      <= 1'b0;
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_len_q      <= w_len_d;
            r_out_val_q  <= w_out_val_d;
            r_out_eop_q  <= w_out_eop_d;
            r_skid_val_q <= w_skid_val_d;
            r_skid_eop_q <= w_skid_eop_d;
            r_rdy_q      <= w_rdy_d;
        end
    end

    // Data payloads need no reset; they are only observed when valid.
    always_ff @(posedge clk) begin
        r_out_dat_q  <= w_out_dat_d;
        r_skid_dat_q <= w_skid_dat_d;
    end

    assign i_rdy = r_rdy_q;
    assign o_val = r_out_val_q;
    assign o_dat = r_out_dat_q;
    assign o_eop = r_out_eop_q;

endmodule
`default_nettype wire

// File: tb/tb_ps_eop_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_eop_inserter
// Purpose  : Self-checking bench for ps_eop_inserter: a table of per-cycle
//            vectors for the framing cases, then scoreboarded sequences for
//            back-pressure, reset mid-packet and a long random stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_eop_inserter;

    localparam int WIDTH     = 8;
    localparam int LEN_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LEN_WIDTH-1:0] i_len;
    logic [WIDTH-1:0]     i_dat;
    logic                 i_val;
    logic                 i_rdy;
    logic [WIDTH-1:0]     o_dat;
    logic                 o_val;
    logic                 o_eop;
    logic                 o_rdy;

    ps_eop_inserter #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .i_len (i_len),
        .i_dat (i_dat),
        .i_val (i_val),
        .i_rdy (i_rdy),
        .o_dat (o_dat),
        .o_val (o_val),
        .o_eop (o_eop),
        .o_rdy (o_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 val;
        logic [LEN_WIDTH-1:0] len;
        logic [WIDTH-1:0]     dat;
        logic                 ordy;
        logic                 ev;
        logic [WIDTH-1:0]     ed;
        logic                 ee;
        logic                 er;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH:0]   sb[$];          // {dat, eop} accepted but not yet emitted
    int               errors = 0;
    int               checks = 0;
    logic [LEN_WIDTH-1:0] m_cnt;
    logic [LEN_WIDTH-1:0] m_len;
    logic             stall_prev;
    logic [WIDTH-1:0] prev_dat;
    logic             prev_eop;
    int               n_acc;
    int               n_out;
    int               saw_rdy_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic val, input logic [LEN_WIDTH-1:0] len, input logic [WIDTH-1:0] dat,
                       input logic ordy, input logic ev, input logic [WIDTH-1:0] ed,
                       input logic ee, input logic er);
        vec_t v;
        v.val = val; v.len = len; v.dat = dat; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ee = ee; v.er = er;
        tbl.push_back(v);
    endtask

    // Reference framing: eop when the word count reaches max(len,1) of the
    // length seen on the packet's first word.
    function automatic logic model_eop(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] eff;
        logic [LEN_WIDTH-1:0] cur;
        eff = (len == 0) ? 1 : len;
        cur = (m_cnt == 0) ? eff : m_len;
        return (m_cnt == cur - 1);
    endfunction

    task automatic model_accept(input logic [LEN_WIDTH-1:0] len, output logic eop);
        eop = model_eop(len);
        if (m_cnt == 0) m_len = (len == 0) ? 1 : len;
        m_cnt = eop ? 0 : m_cnt + 1;
    endtask

    // One clock with scoreboard bookkeeping; inputs are set by the caller.
    task automatic cycle();
        logic [WIDTH:0] e;
        logic           eop;
        @(negedge clk);
        if (!reset) begin
            if (stall_prev) begin
                chk("stall_o_dat", o_dat, prev_dat);
                chk("stall_o_eop", o_eop, prev_eop);
            end
            stall_prev = o_val && !o_rdy;
            prev_dat   = o_dat;
            prev_eop   = o_eop;
            if (o_val && o_rdy) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_o_dat", o_dat, e[WIDTH:1]);
                    chk("sb_o_eop", o_eop, e[0]);
                    n_out++;
                end
            end
            if (i_val && i_rdy) begin
                model_accept(i_len, eop);
                sb.push_back({i_dat, eop});
                n_acc++;
            end
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            chk("i_rdy_vs_fill", i_rdy, (sb.size() < 2) ? 1 : 0);
            if (!i_rdy) saw_rdy_low++;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        i_val = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_o_val", o_val, 0);
            chk("rst_o_eop", o_eop, 0);
            chk("rst_i_rdy", i_rdy, 0);
        end
        reset = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_len = 1;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_i_rdy", i_rdy, 1);
        chk("post_rst_o_val", o_val, 0);
    endtask

    task automatic drain(input string name);
        i_val = 1'b0;
        o_rdy = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) cycle();
        chk({name, "_drain_left"}, sb.size(), 0);
        cycle();
        chk({name, "_drain_o_val"}, o_val, 0);
    endtask

    initial begin
        reset = 1'b1;
        i_val = 1'b0;
        i_len = 4;
        i_dat = '0;
        o_rdy = 1'b1;
        stall_prev = 1'b0;

        // ---------------- table-driven framing vectors ----------------
        for (int k = 1; k <= 12; k++) add(1, 4, WIDTH'(k), 1, 1, WIDTH'(k), (k % 4 == 0), 1);
        add(0, 4, 0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 3; k++) add(1, 0, WIDTH'(8'h20 + k), 1, 1, WIDTH'(8'h20 + k), 1, 1);
        for (int k = 1; k <= 3; k++) add(1, 1, WIDTH'(8'h30 + k), 1, 1, WIDTH'(8'h30 + k), 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            add(1, (k == 1) ? 3 : 5, WIDTH'(8'h40 + k), 1, 1, WIDTH'(8'h40 + k), (k == 3 || k == 8), 1);
        add(0, 5, 0, 1, 0, 0, 0, 1);

        do_reset(3);
        foreach (tbl[i]) begin
            i_val = tbl[i].val;
            i_len = tbl[i].len;
            i_dat = tbl[i].dat;
            o_rdy = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk("tbl_i_rdy", i_rdy, tbl[i].er);
            chk("tbl_o_val", o_val, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_o_dat", o_dat, tbl[i].ed);
                chk("tbl_o_eop", o_eop, tbl[i].ee);
            end
        end

        // ---------------- back-pressure: o_rdy low for 5 cycles ----------------
        do_reset(2);
        saw_rdy_low = 0;
        i_len = 3;
        i_val = 1'b1;
        for (int c = 0; c < 14; c++) begin
            o_rdy = !(c >= 3 && c < 8);
            i_dat = WIDTH'(8'h50 + c);
            cycle();
        end
        chk("stall_saw_rdy_low", (saw_rdy_low > 0) ? 1 : 0, 1);
        drain("stall");

        // ---------------- reset after word 2 of a 4-word packet ----------------
        do_reset(2);
        i_len = 4;
        o_rdy = 1'b0;
        i_val = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_dat = WIDTH'(8'hA1 + k);
            cycle();
        end
        do_reset(2);
        n_out = 0;
        i_len = 4;
        o_rdy = 1'b1;
        i_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_dat = WIDTH'(8'hB1 + k);
            cycle();
        end
        drain("rst_mid");
        chk("rst_mid_count", n_out, 4);

        // ---------------- random stream, i_len = 7 ----------------
        do_reset(2);
        n_acc = 0;
        n_out = 0;
        i_len = 7;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            i_val = (n_acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            o_rdy = 1'($urandom_range(0, 1));
            i_dat = WIDTH'($urandom);
            cycle();
        end
        chk("random_accepted", n_acc, 10000);
        drain("random");
        chk("random_emitted", n_out, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
